// File: rtl/onewire_slave.sv
// Standard-speed 1-wire ROM-only responder: presence on bus reset, ROM command reception,
// Read ROM / Search ROM / Skip ROM service. owr_e=1 pulls the open-drain bus low.
module onewire_slave #(
    parameter int          CLK_US = 33,
    parameter logic [63:0] ROM_ID = 64'h2D00000012345601,
    parameter int          T_RSTL = 400,
    parameter int          T_PDH  = 30,
    parameter int          T_PDL  = 120,
    parameter int          T_SMP  = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       owr_i,
    output logic       owr_e,
    output logic [7:0] cmd,
    output logic       cmd_vld,
    output logic       busy
);

    localparam logic [15:0] C_RSTL = 16'(T_RSTL * CLK_US);
    // Presence delay is shortened by the synchroniser + edge-detect latency
    localparam logic [15:0] C_PDH  = 16'(T_PDH * CLK_US - 3);
    localparam logic [15:0] C_PDL  = 16'(T_PDL * CLK_US);
    localparam logic [15:0] C_SMP  = 16'(T_SMP * CLK_US);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_PRES_WAIT = 3'd1;
    localparam logic [2:0] S_PRES_LOW  = 3'd2;
    localparam logic [2:0] S_CMD       = 3'd3;
    localparam logic [2:0] S_ROM_TX    = 3'd4;
    localparam logic [2:0] S_SRCH_B    = 3'd5;
    localparam logic [2:0] S_SRCH_C    = 3'd6;
    localparam logic [2:0] S_SRCH_W    = 3'd7;

    logic        r_s1, r_s2, r_sp;
    logic [15:0] r_tcnt;
    logic [15:0] r_tmr;
    logic [2:0]  r_state;
    logic        r_slot;
    logic [5:0]  r_bcnt;
    logic [7:0]  r_sh;
    logic        r_owr_e;
    logic [7:0]  r_cmd;
    logic        r_cmd_vld;

    logic w_fall, w_rise, w_bus_rst, w_rom_bit, w_tx_bit, w_smp_done, w_slot_start;
    logic [7:0] w_sh_next;

    assign w_fall       = r_sp & ~r_s2;
    assign w_rise       = ~r_sp & r_s2;
    assign w_bus_rst    = w_rise && (r_tcnt >= C_RSTL);
    assign w_rom_bit    = ROM_ID[r_bcnt];
    assign w_tx_bit     = (r_state == S_SRCH_C) ? ~w_rom_bit : w_rom_bit;
    assign w_smp_done   = (r_tmr == C_SMP - 16'd1);
    // Our own drive holds the bus low, so any edge seen while driving is not a master slot
    assign w_slot_start = w_fall && !r_owr_e;
    assign w_sh_next    = {r_s2, r_sh[7:1]};

    assign owr_e   = r_owr_e;
    assign cmd     = r_cmd;
    assign cmd_vld = r_cmd_vld;
    assign busy    = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= 1'b1;
            r_s2   <= 1'b1;
            r_sp   <= 1'b1;
            r_tcnt <= 16'd0;
        end else begin
            r_s1 <= owr_i;
            r_s2 <= r_s1;
            r_sp <= r_s2;
            if (w_fall || w_rise)
                r_tcnt <= 16'd0;
            else if (r_tcnt != 16'hFFFF)
                r_tcnt <= r_tcnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_tmr     <= 16'd0;
            r_slot    <= 1'b0;
            r_bcnt    <= 6'd0;
            r_sh      <= 8'h00;
            r_owr_e   <= 1'b0;
            r_cmd     <= 8'h00;
            r_cmd_vld <= 1'b0;
        end else begin
            r_cmd_vld <= 1'b0;
            if (w_bus_rst) begin
                r_state <= S_PRES_WAIT;
                r_tmr   <= 16'd0;
                r_slot  <= 1'b0;
                r_bcnt  <= 6'd0;
                r_owr_e <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_owr_e <= 1'b0;
                        r_slot  <= 1'b0;
                    end
                    S_PRES_WAIT: begin
                        if (r_tmr == C_PDH - 16'd1) begin
                            r_state <= S_PRES_LOW;
                            r_owr_e <= 1'b1;
                            r_tmr   <= 16'd0;
                        end else begin
                            r_tmr <= r_tmr + 16'd1;
                        end
                    end
                    S_PRES_LOW: begin
                        if (r_tmr == C_PDL - 16'd1) begin
                            r_state <= S_CMD;
                            r_owr_e <= 1'b0;
                            r_bcnt  <= 6'd0;
                            r_slot  <= 1'b0;
                            r_tmr   <= 16'd0;
                        end else begin
                            r_tmr <= r_tmr + 16'd1;
                        end
                    end
                    S_CMD, S_SRCH_W: begin
                        if (w_slot_start) begin
                            r_slot <= 1'b1;
                            r_tmr  <= 16'd0;
                        end else if (r_slot) begin
                            if (w_smp_done) begin
                                r_slot <= 1'b0;
                                if (r_state == S_CMD) begin
                                    r_sh <= w_sh_next;
                                    if (r_bcnt == 6'd7) begin
                                        r_cmd     <= w_sh_next;
                                        r_cmd_vld <= 1'b1;
                                        r_bcnt    <= 6'd0;
                                        case (w_sh_next)
                                            8'h33:   r_state <= S_ROM_TX;
                                            8'hF0:   r_state <= S_SRCH_B;
                                            default: r_state <= S_IDLE;
                                        endcase
                                    end else begin
                                        r_bcnt <= r_bcnt + 6'd1;
                                    end
                                end else if (r_s2 != w_rom_bit || r_bcnt == 6'd63) begin
                                    r_state <= S_IDLE;
                                end else begin
                                    r_bcnt  <= r_bcnt + 6'd1;
                                    r_state <= S_SRCH_B;
                                end
                            end else begin
                                r_tmr <= r_tmr + 16'd1;
                            end
                        end
                    end
                    S_ROM_TX, S_SRCH_B, S_SRCH_C: begin
                        if (w_slot_start) begin
                            r_slot  <= 1'b1;
                            r_tmr   <= 16'd0;
                            r_owr_e <= ~w_tx_bit;
                        end else if (r_slot) begin
                            if (w_smp_done) begin
                                r_slot  <= 1'b0;
                                r_owr_e <= 1'b0;
                                if (r_state == S_SRCH_B)
                                    r_state <= S_SRCH_C;
                                else if (r_state == S_SRCH_C)
                                    r_state <= S_SRCH_W;
                                else if (r_bcnt == 6'd63)
                                    r_state <= S_IDLE;
                                else
                                    r_bcnt <= r_bcnt + 6'd1;
                            end else begin
                                r_tmr <= r_tmr + 16'd1;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_onewire_slave.sv
// Randomised bus-master bench for onewire_slave with queue-based scoreboard checking.
`timescale 1ns/1ps
module tb_onewire_slave;

    localparam int          CLK_US = 2;
    localparam logic [63:0] ROM    = 64'h2D00000012345601;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       r_m_low = 1'b0;
    logic       w_bus;
    logic       owr_e;
    logic [7:0] cmd;
    logic       cmd_vld;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;

    logic       exp_bit_q[$];
    logic [7:0] exp_cmd_q[$];
    event       ev_smp;

    assign w_bus = ~(r_m_low | owr_e);

    onewire_slave #(.CLK_US(CLK_US), .ROM_ID(ROM)) dut (
        .clk(clk), .rst_n(rst_n), .owr_i(w_bus), .owr_e(owr_e),
        .cmd(cmd), .cmd_vld(cmd_vld), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input longint act, input longint lo, input longint hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic us(input int n);
        repeat (n * CLK_US) @(negedge clk);
    endtask

    // Master bus-level primitives
    task automatic wr_bit(input logic b);
        int lo;
        lo = b ? $urandom_range(1, 6) : $urandom_range(50, 58);
        r_m_low = 1'b1;
        us(lo);
        r_m_low = 1'b0;
        us(62 - lo);
    endtask

    task automatic wr_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) wr_bit(v[i]);
    endtask

    task automatic rd_slot(input logic e);
        exp_bit_q.push_back(e);
        exp_bit_q.push_back(1'b1);
        r_m_low = 1'b1;
        us(2);
        r_m_low = 1'b0;
        us(13);
        ->ev_smp;
        us(25);
        ->ev_smp;
        us(22);
    endtask

    task automatic bus_rst_pres();
        int n, m;
        r_m_low = 1'b1;
        us(480);
        r_m_low = 1'b0;
        n = 0;
        while (owr_e !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk_rng("pres_delay", n, 30 * CLK_US - 2, 30 * CLK_US + 2);
        m = 0;
        while (owr_e === 1'b1 && m < 1000) begin
            @(negedge clk);
            m++;
        end
        chk_rng("pres_len", m, 120 * CLK_US - 2, 120 * CLK_US + 2);
        chk("pres_busy", busy, 1);
        us(5);
    endtask

    // Monitors: bus level at master sample points, and every cmd_vld pulse
    initial forever begin
        @(ev_smp);
        if (exp_bit_q.size() == 0) begin
            chk("rd_unexpected", 1, 0);
        end else begin
            logic e;
            e = exp_bit_q.pop_front();
            chk("rd_bit", w_bus, e);
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmd_vld === 1'b1) begin
            if (exp_cmd_q.size() == 0)
                chk("cmd_vld_extra", cmd, 16'hFFFF);
            else
                chk("cmd", cmd, exp_cmd_q.pop_front());
        end
    end

    // Reference model: the master's view of one search pass; k = index of wrong direction (64 = none)
    task automatic srch(input int k, input int extra);
        logic [63:0] rom;
        logic        b;
        logic        desel;
        int          x;
        rom = ROM;
        desel = 1'b0;
        x = extra;
        bus_rst_pres();
        exp_cmd_q.push_back(8'hF0);
        wr_byte(8'hF0);
        for (int i = 0; i < 64; i++) begin
            b = rom[i];
            if (!desel) begin
                rd_slot(b);
                rd_slot(~b);
                wr_bit((i == k) ? ~b : b);
                if (i == k) desel = 1'b1;
            end else if (x > 0) begin
                rd_slot(1'b1);
                rd_slot(1'b1);
                wr_bit(1'($urandom));
                x--;
            end
        end
        chk("srch_busy_end", busy, 0);
    endtask

    initial begin
        #(200000 * 10);
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] rom;
        logic [7:0]  c;
        bit          saw;
        int          j;
        rom = ROM;

        repeat (4) @(negedge clk);
        chk("rst_owr_e", owr_e, 0);
        chk("rst_cmd", cmd, 0);
        chk("rst_cmd_vld", cmd_vld, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        us(10);

        // Short low pulse is not a bus reset
        r_m_low = 1'b1;
        us(300);
        r_m_low = 1'b0;
        saw = 1'b0;
        repeat (200 * CLK_US) begin
            @(negedge clk);
            if (owr_e === 1'b1) saw = 1'b1;
        end
        chk("short_rst_no_pres", saw, 0);
        chk("short_rst_busy", busy, 0);

        // Read ROM
        bus_rst_pres();
        exp_cmd_q.push_back(8'h33);
        wr_byte(8'h33);
        for (int i = 0; i < 64; i++) rd_slot(rom[i]);
        chk("readrom_busy_end", busy, 0);

        // Search ROM: full match, wrong at bit 5, wrong at random bit
        srch(64, 0);
        srch(5, 4);
        srch($urandom_range(0, 10), 3);

        // Bus reset in the middle of a ROM transfer restarts at bit 0
        bus_rst_pres();
        exp_cmd_q.push_back(8'h33);
        wr_byte(8'h33);
        for (int i = 0; i < 10; i++) rd_slot(rom[i]);
        bus_rst_pres();
        exp_cmd_q.push_back(8'h33);
        wr_byte(8'h33);
        for (int i = 0; i < 16; i++) rd_slot(rom[i]);

        // Commands with no data phase leave the bus alone
        for (int t = 0; t < 3; t++) begin
            if (t == 0) c = 8'h55;
            else if (t == 1) c = 8'hCC;
            else begin
                c = 8'($urandom_range(0, 255));
                while (c == 8'h33 || c == 8'hF0) c = 8'($urandom_range(0, 255));
            end
            bus_rst_pres();
            exp_cmd_q.push_back(c);
            wr_byte(c);
            for (int i = 0; i < 16; i++) rd_slot(1'b1);
            chk("nodata_busy", busy, 0);
        end

        // rst_n during an active drive releases the bus at once
        bus_rst_pres();
        exp_cmd_q.push_back(8'h33);
        wr_byte(8'h33);
        j = 0;
        while (j < 63 && rom[j] == 1'b1) begin
            rd_slot(1'b1);
            j++;
        end
        r_m_low = 1'b1;
        us(5);
        r_m_low = 1'b0;
        @(negedge clk);
        chk("drive_before_rst", owr_e, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_owr_e", owr_e, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_cmd", cmd, 0);
        us(2);
        @(negedge clk);
        rst_n = 1'b1;
        us(20);

        chk("bit_queue_drained", exp_bit_q.size(), 0);
        chk("cmd_queue_drained", exp_cmd_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
